// File: rtl/traffic_light_pkg.sv
// Shared definitions for the vehicle signal head and the pedestrian crossing controller.
package traffic_light_pkg;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] DARK   = 3'b000;

    typedef enum logic [2:0] {
        PED_IDLE,
        PED_CLEAR,
        PED_WALK,
        PED_FLASH,
        PED_DONE
    } ped_state_t;

endpackage

// File: rtl/ped_walk_ctrl_blink_gen.sv
// Half-period square-wave generator for the flashing DON'T-WALK lamp.
// level_o is the lamp level for the coming cycle, so the parent can register it.
module blink_gen #(
    parameter int BLINK = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic restart_i,
    input  logic run_i,
    output logic level_o
);

    localparam int HW = (BLINK > 1) ? $clog2(BLINK) : 1;
    localparam logic [HW-1:0] HALF_LD = HW'(BLINK - 1);

    logic          level_q, level_d;
    logic [HW-1:0] half_q,  half_d;

    // A restart always begins with the lit half of the period.
    always_comb begin
        level_d = level_q;
        half_d  = half_q;
        if (restart_i) begin
            level_d = 1'b1;
            half_d  = HALF_LD;
        end else if (run_i) begin
            if (half_q == '0) begin
                level_d = ~level_q;
                half_d  = HALF_LD;
            end else begin
                half_d = half_q - HW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= 1'b1;
            half_q  <= HALF_LD;
        end else begin
            level_q <= level_d;
            half_q  <= half_d;
        end
    end

    assign level_o = level_d;

endmodule

// File: rtl/ped_walk_ctrl.sv
// Pedestrian crossing controller: grants one WALK + flashing clearance per steady
// vehicle red, drives a remaining-time countdown and flags sticky WALK conflicts.
module ped_walk_ctrl
    import traffic_light_pkg::*;
#(
    parameter int CLEAR_ON = 2,
    parameter int WALK_ON  = 8,
    parameter int FLASH_ON = 4,
    parameter int BLINK    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic [2:0] color_i,
    input  logic       req_i,
    output logic       walk_o,
    output logic       dont_walk_o,
    output logic [7:0] countdown_o,
    output logic       conflict_o
);

    localparam int CW_SUM   = $clog2(WALK_ON + FLASH_ON + 1);
    localparam int CW_CLEAR = $clog2(CLEAR_ON + 1);
    localparam int CW       = (CW_SUM > CW_CLEAR) ? CW_SUM : CW_CLEAR;

    localparam logic [CW-1:0] CLEAR_LD = CW'(CLEAR_ON - 1);
    localparam logic [CW-1:0] WALK_LD  = CW'(WALK_ON - 1);
    localparam logic [CW-1:0] FLASH_LD = CW'(FLASH_ON - 1);
    localparam logic [31:0]   FLASH_U  = 32'(FLASH_ON);

    ped_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          reqPend_q, reqPend_d;
    logic          conflict_q, conflict_d;
    logic          walk_q, walk_d;
    logic          dontWalk_q, dontWalk_d;
    logic [7:0]    countdown_q, countdown_d;
    logic [31:0]   cdNext;
    logic          isRed;
    logic          blinkLevel;

    assign isRed = (color_i == RED);

    // Any non-red aspect aborts a crossing; during WALK/FLASH that is a safety conflict.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        reqPend_d  = reqPend_q;
        conflict_d = conflict_q;
        if (!en_i) begin
            state_d = PED_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                PED_IDLE: begin
                    reqPend_d = reqPend_q | req_i;
                    if (isRed && (reqPend_q || req_i)) begin
                        state_d = PED_CLEAR;
                        cnt_d   = CLEAR_LD;
                    end
                end
                PED_CLEAR: begin
                    reqPend_d = reqPend_q | req_i;
                    if (!isRed) begin
                        state_d = PED_IDLE;
                    end else if (cnt_q == '0) begin
                        state_d   = PED_WALK;
                        cnt_d     = WALK_LD;
                        reqPend_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                PED_WALK: begin
                    if (!isRed) begin
                        conflict_d = 1'b1;
                        state_d    = PED_IDLE;
                    end else if (cnt_q == '0) begin
                        state_d = PED_FLASH;
                        cnt_d   = FLASH_LD;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                PED_FLASH: begin
                    if (!isRed) begin
                        conflict_d = 1'b1;
                        state_d    = PED_IDLE;
                    end else if (cnt_q == '0) begin
                        state_d = PED_DONE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                PED_DONE: begin
                    reqPend_d = reqPend_q | req_i;
                    if (!isRed) begin
                        state_d = PED_IDLE;
                    end
                end
                default: state_d = PED_IDLE;
            endcase
        end
    end

    blink_gen #(
        .BLINK(BLINK)
    ) u_blink (
        .clk      (clk),
        .rst      (rst),
        .restart_i((state_d == PED_FLASH) && (state_q != PED_FLASH)),
        .run_i    (state_d == PED_FLASH),
        .level_o  (blinkLevel)
    );

    // Outputs are derived from the next state so they switch on the same edge.
    always_comb begin
        cdNext = 32'd0;
        if (state_d == PED_WALK) begin
            cdNext = 32'(cnt_d) + FLASH_U + 32'd1;
        end else if (state_d == PED_FLASH) begin
            cdNext = 32'(cnt_d) + 32'd1;
        end
        countdown_d = (cdNext > 32'd255) ? 8'hFF : cdNext[7:0];
        walk_d      = (state_d == PED_WALK);
        dontWalk_d  = (state_d == PED_FLASH) ? blinkLevel : (state_d != PED_WALK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= PED_IDLE;
            cnt_q       <= '0;
            reqPend_q   <= 1'b0;
            conflict_q  <= 1'b0;
            walk_q      <= 1'b0;
            dontWalk_q  <= 1'b1;
            countdown_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            reqPend_q   <= reqPend_d;
            conflict_q  <= conflict_d;
            walk_q      <= walk_d;
            dontWalk_q  <= dontWalk_d;
            countdown_q <= countdown_d;
        end
    end

    assign walk_o      = walk_q;
    assign dont_walk_o = dontWalk_q;
    assign countdown_o = countdown_q;
    assign conflict_o  = conflict_q;

endmodule

// File: tb/tb_ped_walk_ctrl.sv
// Self-checking bench for ped_walk_ctrl: a timeline-based crossing model checked every
// cycle, literal expectations for the key scenarios, then randomized vehicle traffic.
module tb_ped_walk_ctrl;
    import traffic_light_pkg::*;

    localparam int CLEAR_ON = 2;
    localparam int WALK_ON  = 8;
    localparam int FLASH_ON = 4;
    localparam int BLINK    = 1;

    localparam int M_IDLE  = 0;
    localparam int M_WAIT  = 1;
    localparam int M_CROSS = 2;
    localparam int M_DONE  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [2:0] color = DARK;
    logic       req = 1'b0;
    logic       walk;
    logic       dontWalk;
    logic [7:0] countdown;
    logic       conflict;

    int tests = 0;
    int fails = 0;
    bit checkOn = 1'b0;

    int edgeCnt = 0;
    int mMode = M_IDLE;
    int tStart = 0;
    bit mPend = 1'b0;
    bit mConflict = 1'b0;

    ped_walk_ctrl #(
        .CLEAR_ON(CLEAR_ON),
        .WALK_ON (WALK_ON),
        .FLASH_ON(FLASH_ON),
        .BLINK   (BLINK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en_i       (en),
        .color_i    (color),
        .req_i      (req),
        .walk_o     (walk),
        .dont_walk_o(dontWalk),
        .countdown_o(countdown),
        .conflict_o (conflict)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Inputs are held for exactly one rising edge; returns shortly after that edge.
    task automatic applyStimulus(input bit r, input bit e, input logic [2:0] c, input bit q);
        rst   = r;
        en    = e;
        color = c;
        req   = q;
        @(posedge clk);
        #2;
    endtask

    // Crossing timeline: WALK starts CLEAR_ON edges after the first red, then the
    // whole WALK+FLASH window is measured as elapsed edges from that start.
    always @(posedge clk) begin
        edgeCnt++;
        if (rst) begin
            mMode = M_IDLE;
            mPend = 1'b0;
            mConflict = 1'b0;
        end else if (!en) begin
            mMode = M_IDLE;
        end else begin
            case (mMode)
                M_IDLE: begin
                    if (color == RED && (mPend || req)) begin
                        mMode = M_WAIT;
                        tStart = edgeCnt + CLEAR_ON;
                    end
                    mPend = mPend | req;
                end
                M_WAIT: begin
                    mPend = mPend | req;
                    if (color != RED) mMode = M_IDLE;
                    else if (edgeCnt >= tStart) begin
                        mMode = M_CROSS;
                        mPend = 1'b0;
                    end
                end
                M_CROSS: begin
                    if (color != RED) begin
                        mConflict = 1'b1;
                        mMode = M_IDLE;
                    end else if (edgeCnt >= tStart + WALK_ON + FLASH_ON) begin
                        mMode = M_DONE;
                    end
                end
                default: begin
                    mPend = mPend | req;
                    if (color != RED) mMode = M_IDLE;
                end
            endcase
        end
    end

    function automatic int expWalk();
        if (mMode != M_CROSS) return 0;
        return (edgeCnt - tStart < WALK_ON) ? 1 : 0;
    endfunction

    function automatic int expDontWalk();
        int el;
        if (mMode != M_CROSS) return 1;
        el = edgeCnt - tStart;
        if (el < WALK_ON) return 0;
        return (((el - WALK_ON) / BLINK) % 2 == 0) ? 1 : 0;
    endfunction

    function automatic int expCountdown();
        int rem;
        if (mMode != M_CROSS) return 0;
        rem = WALK_ON + FLASH_ON - (edgeCnt - tStart);
        return (rem > 255) ? 255 : rem;
    endfunction

    always @(negedge clk) begin
        if (checkOn) begin
            checkOutput("walk", int'(walk), expWalk());
            checkOutput("dont_walk", int'(dontWalk), expDontWalk());
            checkOutput("countdown", int'(countdown), expCountdown());
            checkOutput("conflict", int'(conflict), int'(mConflict));
        end
    end

    initial begin
        int walkCycles;
        int cdNonZero;
        int segLeft;
        logic [2:0] col;
        bit r, e, q;

        applyStimulus(1, 0, DARK, 0);
        applyStimulus(1, 0, DARK, 0);
        checkOn = 1'b1;
        checkOutput("reset_walk", int'(walk), 0);
        checkOutput("reset_dont_walk", int'(dontWalk), 1);
        checkOutput("reset_countdown", int'(countdown), 0);
        checkOutput("reset_conflict", int'(conflict), 0);

        // No request over a full vehicle cycle: lamps stay solid DON'T-WALK.
        walkCycles = 0;
        cdNonZero = 0;
        for (int i = 0; i < 33; i++) begin
            applyStimulus(0, 1, (i < 10) ? GREEN : (i < 13) ? YELLOW : RED, 0);
            walkCycles += int'(walk) + int'(!dontWalk);
            cdNonZero += (countdown != 8'd0) ? 1 : 0;
        end
        checkOutput("noreq_walk_or_dark", walkCycles, 0);
        checkOutput("noreq_countdown", cdNonZero, 0);

        // Normal crossing: request during green, red sampled at n=0.
        applyStimulus(0, 1, GREEN, 1);
        repeat (3) applyStimulus(0, 1, GREEN, 0);
        applyStimulus(0, 1, YELLOW, 0);
        for (int n = 0; n < 16; n++) begin
            applyStimulus(0, 1, RED, 0);
            case (n)
                1:  checkOutput("norm_clear_walk", int'(walk), 0);
                2: begin
                    checkOutput("norm_walk_start", int'(walk), 1);
                    checkOutput("norm_cd_start", int'(countdown), 12);
                end
                9: begin
                    checkOutput("norm_walk_last", int'(walk), 1);
                    checkOutput("norm_cd_walk_last", int'(countdown), 5);
                end
                10: begin
                    checkOutput("norm_flash0_walk", int'(walk), 0);
                    checkOutput("norm_flash0_dw", int'(dontWalk), 1);
                end
                11: checkOutput("norm_flash1_dw", int'(dontWalk), 0);
                12: checkOutput("norm_flash2_dw", int'(dontWalk), 1);
                13: begin
                    checkOutput("norm_flash3_dw", int'(dontWalk), 0);
                    checkOutput("norm_cd_last", int'(countdown), 1);
                end
                14: begin
                    checkOutput("norm_done_dw", int'(dontWalk), 1);
                    checkOutput("norm_done_cd", int'(countdown), 0);
                end
                default: ;
            endcase
        end
        repeat (3) applyStimulus(0, 1, GREEN, 0);

        // Red ends during clearance: request survives and is served on the next red.
        applyStimulus(0, 1, GREEN, 1);
        applyStimulus(0, 1, RED, 0);
        applyStimulus(0, 1, GREEN, 0);
        checkOutput("clr_abort_conflict", int'(conflict), 0);
        checkOutput("clr_abort_dw", int'(dontWalk), 1);
        repeat (3) applyStimulus(0, 1, GREEN, 0);
        for (int n = 0; n < 16; n++) begin
            applyStimulus(0, 1, RED, 0);
            if (n == 1) checkOutput("clr_retry_wait", int'(walk), 0);
            if (n == 2) checkOutput("clr_retry_walk", int'(walk), 1);
        end
        repeat (2) applyStimulus(0, 1, GREEN, 0);

        // Disable mid-WALK: back to idle, countdown cleared, no conflict.
        applyStimulus(0, 1, GREEN, 1);
        for (int n = 0; n < 5; n++) applyStimulus(0, 1, RED, 0);
        applyStimulus(0, 0, RED, 0);
        checkOutput("dis_walk", int'(walk), 0);
        checkOutput("dis_cd", int'(countdown), 0);
        checkOutput("dis_conflict", int'(conflict), 0);
        repeat (4) applyStimulus(0, 1, RED, 0);
        repeat (2) applyStimulus(0, 1, GREEN, 0);

        // Reset mid-FLASH returns every output to its reset value.
        applyStimulus(0, 1, GREEN, 1);
        for (int n = 0; n < 12; n++) applyStimulus(0, 1, RED, 0);
        applyStimulus(1, 1, RED, 1);
        checkOutput("rst_walk", int'(walk), 0);
        checkOutput("rst_dw", int'(dontWalk), 1);
        checkOutput("rst_cd", int'(countdown), 0);
        repeat (3) applyStimulus(0, 1, RED, 0);
        checkOutput("rst_req_cleared", int'(walk), 0);
        repeat (2) applyStimulus(0, 1, GREEN, 0);

        // Green forced on the 4th WALK cycle raises the sticky conflict.
        applyStimulus(0, 1, GREEN, 1);
        for (int n = 0; n < 5; n++) applyStimulus(0, 1, RED, 0);
        applyStimulus(0, 1, GREEN, 0);
        checkOutput("cfl_conflict", int'(conflict), 1);
        checkOutput("cfl_walk", int'(walk), 0);
        checkOutput("cfl_dw", int'(dontWalk), 1);
        applyStimulus(0, 1, GREEN, 1);
        for (int n = 0; n < 16; n++) begin
            applyStimulus(0, 1, RED, 0);
            if (n == 2) checkOutput("cfl_next_walk", int'(walk), 1);
        end
        checkOutput("cfl_sticky", int'(conflict), 1);
        applyStimulus(1, 0, DARK, 0);

        // Request held through a long red: exactly one WALK window.
        applyStimulus(0, 1, GREEN, 1);
        walkCycles = 0;
        for (int n = 0; n < 40; n++) begin
            applyStimulus(0, 1, RED, 1);
            walkCycles += int'(walk);
        end
        checkOutput("long_red_walk_cycles", walkCycles, WALK_ON);
        applyStimulus(0, 1, GREEN, 1);
        applyStimulus(0, 1, GREEN, 0);
        for (int n = 0; n < 3; n++) applyStimulus(0, 1, RED, 0);
        checkOutput("long_red_next_walk", int'(walk), 1);
        repeat (14) applyStimulus(0, 1, RED, 0);

        // Randomized vehicle aspects, requests, disables and occasional resets.
        segLeft = 0;
        col = RED;
        for (int i = 0; i < 3000; i++) begin
            if (segLeft == 0) begin
                case ($urandom_range(0, 5))
                    0, 1, 5: col = RED;
                    2:       col = GREEN;
                    3:       col = YELLOW;
                    default: col = DARK;
                endcase
                segLeft = $urandom_range(1, 24);
            end
            segLeft--;
            r = ($urandom_range(0, 199) == 0);
            e = ($urandom_range(0, 49) != 0);
            q = e && ($urandom_range(0, 9) == 0);
            applyStimulus(r, e, col, q);
        end

        @(negedge clk);
        checkOn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
